arb_rr4: RTL and testbench

ARB_RR4 -- requirements
Module: arb_rr4

---
 rtl/arb_rr4.sv | 162 ++++++++++++++++
 tb/tb_arb_rr4.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr4.sv
// Four-requester round-robin arbiter with level-held requests and registered one-hot grant.
// Optional grant-hold limit is built only when ARB_TIMEOUT_EN is defined.
module arb_rr4 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] idx_q, idx_d;
    logic       vld_q, vld_d;
    logic       timeout_q, timeout_d;
    logic       new_grant;
    logic       expire;

    logic [1:0] idx_inc;
    logic [1:0] scan_base;
    logic [3:0] scan_req;
    logic [3:0] rot;
    logic [1:0] scan_off;
    logic [1:0] scan_idx;
    logic       scan_hit;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("arb_rr4: TIMEOUT must be in 2..255");
    end

    assign idx_inc = idx_q + 2'd1;

    // From IDLE scan from ptr; from GRANT the scan starts after the current holder,
    // which is masked so a revoked holder cannot win its own re-arbitration.
    always_comb begin
        if (state_q == ST_GRANT) begin
            scan_base = idx_inc;
            scan_req  = req & ~(4'b0001 << idx_q);
        end else begin
            scan_base = ptr_q;
            scan_req  = req;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot[gi] = scan_req[2'(scan_base + 2'(gi))];
    end

    always_comb begin
        scan_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) begin
                scan_off = 2'(k);
            end
        end
    end

    assign scan_hit = |rot;
    assign scan_idx = scan_base + scan_off;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       hold_ok;

    assign hold_ok = en && (state_q == ST_GRANT) && req[idx_q];
    assign expire  = hold_ok && (hold_cnt_q == 8'(TIMEOUT - 1));

    // Counts completed cycles of the current grant; zero in its first visible cycle.
    always_comb begin
        if (new_grant) begin
            hold_cnt_d = 8'd0;
        end else if (state_d == ST_GRANT) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
            hold_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        timeout_d = 1'b0;
        new_grant = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            idx_d   = 2'd0;
            vld_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (scan_hit) begin
                state_d   = ST_GRANT;
                gnt_d     = 4'b0001 << scan_idx;
                idx_d     = scan_idx;
                vld_d     = 1'b1;
                new_grant = 1'b1;
            end
        end else if (!req[idx_q] || expire) begin
            // Release or forced revocation: hand over on this same edge if anyone waits.
            ptr_d     = idx_inc;
            timeout_d = expire;
            if (scan_hit) begin
                state_d   = ST_GRANT;
                gnt_d     = 4'b0001 << scan_idx;
                idx_d     = scan_idx;
                vld_d     = 1'b1;
                new_grant = 1'b1;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                idx_d   = 2'd0;
                vld_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            idx_q     <= 2'd0;
            vld_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            vld_q     <= vld_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arb_rr4.sv
// Self-checking bench for arb_rr4: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the round-robin rules.
module tb_arb_rr4;

    localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b1;

    // Model state: current holder (-1 none), pointer, cycles the grant has been visible.
    int m_cur  = -1;
    int m_ptr  = 0;
    int m_held = 0;
    bit m_to   = 1'b0;

    arb_rr4 #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input int p, input logic [3:0] r, input int excl);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [3:0] q);
        int w;
        m_to = 1'b0;
        if (r) begin
            m_cur = -1; m_ptr = 0; m_held = 0;
        end else if (!e) begin
            m_cur = -1; m_held = 0;
        end else if (m_cur < 0) begin
            w = pick(m_ptr, q, -1);
            m_cur = w; m_held = (w >= 0) ? 1 : 0;
        end else if (!q[m_cur]) begin
            m_ptr = (m_cur + 1) % 4;
            w = pick(m_ptr, q, -1);
            m_cur = w; m_held = (w >= 0) ? 1 : 0;
        end else if (TO_EN && m_held >= TO) begin
            m_ptr = (m_cur + 1) % 4;
            w = pick(m_ptr, q, m_cur);
            m_cur = w; m_held = (w >= 0) ? 1 : 0;
            m_to = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    function automatic logic [7:0] exp_vec();
        if (m_cur < 0) return {7'b0, m_to};
        return {4'(1 << m_cur), 2'(m_cur), 1'b1, m_to};
    endfunction

    // Drive inputs, advance one edge, update the model, sample on the falling edge.
    task automatic tick(input logic r, input logic e, input logic [3:0] q);
        rst = r; en = e; req = q;
        @(posedge clk);
        model_step(r, e, q);
        @(negedge clk);
        if (verbose)
            $display("txn t=%0t rst=%b en=%b req=%b -> gnt=%b idx=%0d vld=%b to=%b",
                     $time, r, e, q, gnt, gnt_idx, gnt_vld, timeout);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 4'hf);
        tick(1'b1, 1'b1, 4'hf);
        checks++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== 8'h00) begin
            errors++;
            $display("FAIL reset got %b want %b", {gnt, gnt_idx, gnt_vld, timeout}, 8'h00);
        end
    endtask

    task automatic test_single();
        tick(1'b1, 1'b0, 4'h0);
        tick(1'b0, 1'b1, 4'b0100);
        checks++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== 8'b0100_10_1_0) begin
            errors++;
            $display("FAIL single got %b want %b", {gnt, gnt_idx, gnt_vld, timeout}, 8'b0100_10_1_0);
        end
        checks++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== exp_vec()) begin
            errors++;
            $display("FAIL single_model got %b want %b", {gnt, gnt_idx, gnt_vld, timeout}, exp_vec());
        end
    endtask

    task automatic test_rr_order();
        int seq[$];
        int idle_cnt;
        logic [3:0] q;
        int want[5] = '{0, 1, 2, 3, 0};
        idle_cnt = 0;
        tick(1'b1, 1'b0, 4'h0);
        for (int c = 0; c < 40 && seq.size() < 5; c++) begin
            q = 4'hf;
            if (m_cur >= 0 && m_held >= 3) q[m_cur] = 1'b0;
            tick(1'b0, 1'b1, q);
            checks++;
            if ({gnt, gnt_idx, gnt_vld, timeout} !== exp_vec()) begin
                errors++;
                $display("FAIL rr_model cyc %0d got %b want %b", c, {gnt, gnt_idx, gnt_vld, timeout}, exp_vec());
            end
            if (!gnt_vld) idle_cnt++;
            else if (seq.size() == 0 || int'(gnt_idx) != seq[$]) seq.push_back(int'(gnt_idx));
        end
        checks++;
        if (seq.size() != 5) begin
            errors++;
            $display("FAIL rr_count got %0d want 5", seq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seq[i] != want[i]) begin
                    errors++;
                    $display("FAIL rr_order pos %0d got %0d want %0d", i, seq[i], want[i]);
                end
            end
        end
        checks++;
        if (idle_cnt != 0) begin
            errors++;
            $display("FAIL rr_idle got %0d idle cycles want 0", idle_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] qs[4] = '{4'b1000, 4'b1001, 4'b0001, 4'b1110};
        logic [7:0] ws[4] = '{8'b1000_11_1_0, 8'b1000_11_1_0, 8'b0001_00_1_0, 8'b0010_01_1_0};
        tick(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, qs[i]);
            checks++;
            if ({gnt, gnt_idx, gnt_vld, timeout} !== ws[i]) begin
                errors++;
                $display("FAIL wrap step %0d got %b want %b", i, {gnt, gnt_idx, gnt_vld, timeout}, ws[i]);
            end
        end
    endtask

    task automatic test_en_drop();
        logic       es[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] qs[4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
        logic [7:0] ws[4] = '{8'b0010_01_1_0, 8'h00, 8'b0010_01_1_0, 8'h00};
        tick(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, es[i], qs[i]);
            checks++;
            if ({gnt, gnt_idx, gnt_vld, timeout} !== ws[i]) begin
                errors++;
                $display("FAIL en_drop step %0d got %b want %b", i, {gnt, gnt_idx, gnt_vld, timeout}, ws[i]);
            end
        end
        // Pointer untouched by en=0, so a full request set restarts at index 0.
        tick(1'b0, 1'b1, 4'hf);
        checks++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== 8'b0001_00_1_0) begin
            errors++;
            $display("FAIL en_ptr got %b want %b", {gnt, gnt_idx, gnt_vld, timeout}, 8'b0001_00_1_0);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] want;
        tick(1'b1, 1'b0, 4'h0);
        for (int c = 0; c < 7; c++) begin
            tick(1'b0, 1'b1, 4'b0011);
            if (TO_EN) want = (c < 4) ? 8'b0001_00_1_0 : ((c == 4) ? 8'b0010_01_1_1 : 8'b0010_01_1_0);
            else       want = 8'b0001_00_1_0;
            checks++;
            if ({gnt, gnt_idx, gnt_vld, timeout} !== want) begin
                errors++;
                $display("FAIL timeout cyc %0d got %b want %b", c, {gnt, gnt_idx, gnt_vld, timeout}, want);
            end
        end
        tick(1'b1, 1'b1, 4'b0011);
        checks++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== 8'h00) begin
            errors++;
            $display("FAIL timeout_rst got %b want %b", {gnt, gnt_idx, gnt_vld, timeout}, 8'h00);
        end
    endtask

    task automatic test_random();
        logic [3:0] q;
        logic r, e;
        q = 4'h0;
        verbose = 1'b0;
        tick(1'b1, 1'b0, 4'h0);
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 19) != 0);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) q[b] = ~q[b];
            tick(r, e, q);
            checks++;
            if ({gnt, gnt_idx, gnt_vld, timeout} !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d got %b want %b", c, {gnt, gnt_idx, gnt_vld, timeout}, exp_vec());
            end
        end
        verbose = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 4'h0;
        test_reset();
        test_single();
        test_rr_order();
        test_wrap();
        test_en_drop();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
